// File: rtl/row_bank_buffer_if.sv
// Producer/consumer bus of the row bank buffer: write side, read side and status.
// The buffer takes the slave modport; the driving side (memory path / scan-out) takes master.
interface row_bank_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_WORDS  = 1024,
  parameter int NUM_BANKS  = 2
);
  localparam int AW = $clog2(ROW_WORDS);
  localparam int LW = $clog2(ROW_WORDS + 1);
  localparam int CW = $clog2(NUM_BANKS + 1);

  logic                  init;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  wr_row_done;
  logic                  wr_ready;
  logic [LW-1:0]         wr_level;
  logic [AW-1:0]         rd_addr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_row_valid;
  logic [LW-1:0]         rd_row_len;
  logic                  rd_row_release;
  logic [CW-1:0]         rows_full;
  logic [1:0]            err;

  modport master (
    output init, wr_data, wr_en, wr_row_done, rd_addr, rd_en, rd_row_release,
    input  wr_ready, wr_level, rd_data, rd_row_valid, rd_row_len, rows_full, err
  );

  modport slave (
    input  init, wr_data, wr_en, wr_row_done, rd_addr, rd_en, rd_row_release,
    output wr_ready, wr_level, rd_data, rd_row_valid, rd_row_len, rows_full, err
  );
endinterface

// File: rtl/row_bank_buffer.sv
// Ring of NUM_BANKS row banks between the memory-read path and LCD scan-out.
// Producer fills and commits rows; consumer reads committed rows and releases them.
module row_bank_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_WORDS  = 1024,
  parameter int NUM_BANKS  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  row_bank_buffer_if.slave bus
);
  localparam int AW    = $clog2(ROW_WORDS);
  localparam int LW    = $clog2(ROW_WORDS + 1);
  localparam int CW    = $clog2(NUM_BANKS + 1);
  localparam int BW    = $clog2(NUM_BANKS);
  localparam int DEPTH = NUM_BANKS << AW;

  typedef enum logic {FILL, STALL} wr_state_e;
  typedef logic [BW-1:0] bank_t;

  wr_state_e             state_q, state_d;
  bank_t                 wr_bank_q, wr_bank_d;
  bank_t                 rd_bank_q, rd_bank_d;
  logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [LW-1:0]         len_q [NUM_BANKS];
  logic [LW-1:0]         len_d [NUM_BANKS];
  logic [1:0]            err_q, err_d;
  logic                  wr_accept, commit, release_ok;
  logic [LW-1:0]         eff_len;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic bank_t bank_inc(input bank_t b);
    return (b == bank_t'(NUM_BANKS - 1)) ? '0 : b + bank_t'(1);
  endfunction

  // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    len_d      = len_q;
    err_d      = err_q;
    wr_accept  = 1'b0;
    commit     = 1'b0;
    release_ok = 1'b0;
    eff_len    = wr_ptr_q;

    if (bus.init) begin
      state_d   = FILL;
      wr_bank_d = '0;
      rd_bank_d = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      len_d     = '{default: '0};
      err_d     = '0;
    end else begin
      wr_accept  = (state_q == FILL) && bus.wr_en && (wr_ptr_q < LW'(ROW_WORDS));
      eff_len    = wr_ptr_q + LW'(wr_accept);
      // An empty row is never committed; the same-cycle word counts toward the length.
      commit     = (state_q == FILL) && bus.wr_row_done && (eff_len != '0);
      release_ok = bus.rd_row_release && (count_q != '0);

      if ((state_q == FILL) ? (bus.wr_en && !wr_accept) : (bus.wr_en || bus.wr_row_done))
        err_d[0] = 1'b1;
      if (bus.rd_row_release && !release_ok)
        err_d[1] = 1'b1;

      if (commit) begin
        len_d[wr_bank_q] = eff_len;
        wr_bank_d        = bank_inc(wr_bank_q);
        wr_ptr_d         = '0;
      end else if (wr_accept) begin
        wr_ptr_d = eff_len;
      end

      if (release_ok)
        rd_bank_d = bank_inc(rd_bank_q);

      count_d = count_q + CW'(commit) - CW'(release_ok);
      state_d = (count_d == CW'(NUM_BANKS)) ? STALL : FILL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FILL;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      len_q     <= '{default: '0};
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      len_q     <= len_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; validity is tracked by count/len instead.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[{wr_bank_q, wr_ptr_q[AW-1:0]}] <= bus.wr_data;
  end

  // Write and read banks never alias, so no read-during-write bypass is needed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rd_data_q <= '0;
    else if (bus.init)
      rd_data_q <= '0;
    else if (bus.rd_en && (count_q != '0))
      rd_data_q <= mem[{rd_bank_q, bus.rd_addr}];
  end

  assign bus.wr_ready     = (state_q == FILL);
  assign bus.wr_level     = wr_ptr_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_row_valid = (count_q != '0);
  assign bus.rd_row_len   = (count_q != '0) ? len_q[rd_bank_q] : '0;
  assign bus.rows_full    = count_q;
  assign bus.err          = err_q;
endmodule
